led_pattern_sequencer: RTL and testbench

Consumes the divided slow clock from the clock divider and drives an LED bank with a selectable animation pattern, entirely in the fast `clock_in` domain. The slow clock is treated as data: it is synchronised and edge-detected into a one-cycle tick, and each tick advances a pattern state machine. The block sits directly downstream of the divider, between it and the board LED pins.

---
 rtl/led_pattern_sequencer.sv | 143 ++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// LED animation sequencer: samples the divided slow clock as data, turns each of its
// rising edges into a one-cycle tick, and steps the selected LED pattern on every tick.
module led_pattern_sequencer #(
  parameter int LED_COUNT = 8
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 slow_clock_in,
  input  logic                 enable_in,
  input  logic [1:0]           mode_in,
  output logic [LED_COUNT-1:0] leds_out,
  output logic                 tick_out,
  output logic                 wrap_out
);

  localparam int CNT_W = $clog2(LED_COUNT + 1);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(LED_COUNT - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(LED_COUNT);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  localparam logic [1:0] SHIFT  = 2'b00;
  localparam logic [1:0] BOUNCE = 2'b01;
  localparam logic [1:0] BLINK  = 2'b10;
  localparam logic [1:0] FILL   = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nx;
  logic [1:0]           active_mode, mode_nx;
  logic [CNT_W-1:0]     pos, pos_nx;      // lit index, blink phase or fill count
  logic                 dir, dir_nx;      // 0 = up, 1 = down
  logic [LED_COUNT-1:0] leds_nx;
  logic                 wrap_nx;
  logic                 sync1, sync2, prev;
  logic                 tick;

  assign tick = sync2 & ~prev;

  function automatic logic [LED_COUNT-1:0] pattern(input logic [1:0] mode,
                                                   input logic [CNT_W-1:0] p);
    logic [LED_COUNT-1:0] pat;
    pat = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      case (mode)
        SHIFT, BOUNCE: pat[i] = (p == CNT_W'(i));
        BLINK:         pat[i] = (p == '0);
        default:       pat[i] = (p > CNT_W'(i));
      endcase
    end
    return pat;
  endfunction

  always_comb begin
    state_nx = state;
    mode_nx  = active_mode;
    pos_nx   = pos;
    dir_nx   = dir;
    leds_nx  = leds_out;
    wrap_nx  = 1'b0;
    case (state)
      IDLE: begin
        pos_nx  = '0;
        dir_nx  = 1'b0;
        leds_nx = '0;
        if (enable_in) begin
          state_nx = RUN;
          mode_nx  = mode_in;
          leds_nx  = pattern(mode_in, '0);
        end
      end
      default: begin
        if (!enable_in) begin
          state_nx = IDLE;
          pos_nx   = '0;
          dir_nx   = 1'b0;
          leds_nx  = '0;
        end else if (tick) begin
          if (mode_in != active_mode) begin
            // mode switch restarts the new pattern instead of stepping
            mode_nx = mode_in;
            pos_nx  = '0;
            dir_nx  = 1'b0;
          end else begin
            case (active_mode)
              SHIFT: begin
                pos_nx  = (pos == TOP) ? '0 : pos + ONE;
                wrap_nx = (pos == TOP);
              end
              BOUNCE: begin
                if (!dir && pos != TOP) begin
                  pos_nx = pos + ONE;
                end else begin
                  pos_nx = pos - ONE;
                  dir_nx = 1'b1;
                end
                if (pos_nx == '0) begin
                  dir_nx  = 1'b0;
                  wrap_nx = 1'b1;
                end
              end
              BLINK: begin
                pos_nx  = (pos == '0) ? ONE : '0;
                wrap_nx = (pos != '0);
              end
              default: begin
                pos_nx  = (pos == FULL) ? '0 : pos + ONE;
                wrap_nx = (pos == FULL);
              end
            endcase
          end
          leds_nx = pattern(mode_nx, pos_nx);
        end
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      prev        <= 1'b1;
      state       <= IDLE;
      active_mode <= SHIFT;
      pos         <= '0;
      dir         <= 1'b0;
      leds_out    <= '0;
      tick_out    <= 1'b0;
      wrap_out    <= 1'b0;
    end else begin
      sync1       <= slow_clock_in;
      sync2       <= sync1;
      prev        <= sync2;
      state       <= state_nx;
      active_mode <= mode_nx;
      pos         <= pos_nx;
      dir         <= dir_nx;
      leds_out    <= leds_nx;
      tick_out    <= tick;
      wrap_out    <= wrap_nx;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed pattern scenarios followed by random traffic,
// all checked cycle by cycle against a phase-counter reference model.
module tb_led_pattern_sequencer;

  localparam int L = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         slow;
  logic         en;
  logic [1:0]   mode;
  logic [L-1:0] leds;
  logic         tick_o;
  logic         wrap_o;

  int errors = 0;
  int checks = 0;
  int wraps  = 0;

  // reference model: sampled slow-clock history and pattern phase k within its period
  bit           hist[$];
  bit           m_run;
  logic [1:0]   m_mode;
  int           m_k;
  logic [L-1:0] m_leds;
  bit           m_tick;
  bit           m_wrap;

  always #5 clk = ~clk;

  led_pattern_sequencer #(.LED_COUNT(L)) dut (
    .clock_in      (clk),
    .reset_n       (rst_n),
    .slow_clock_in (slow),
    .enable_in     (en),
    .mode_in       (mode),
    .leds_out      (leds),
    .tick_out      (tick_o),
    .wrap_out      (wrap_o)
  );

  function automatic int period(input logic [1:0] m);
    case (m)
      2'd0:    return L;
      2'd1:    return 2 * L - 2;
      2'd2:    return 2;
      default: return L + 1;
    endcase
  endfunction

  function automatic logic [L-1:0] pat(input logic [1:0] m, input int k);
    int p;
    case (m)
      2'd0: return L'(64'd1 << k);
      2'd1: begin
        p = (k < L) ? k : 2 * L - 2 - k;
        return L'(64'd1 << p);
      end
      2'd2:    return (k == 0) ? {L{1'b1}} : {L{1'b0}};
      default: return L'((64'd1 << k) - 64'd1);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    bit tk;
    @(posedge clk);
    tk = hist[1] && !hist[2];
    if (!rst_n) begin
      m_run  = 1'b0;
      m_mode = 2'd0;
      m_k    = 0;
      m_leds = '0;
      m_tick = 1'b0;
      m_wrap = 1'b0;
      hist   = '{1'b1, 1'b1, 1'b1};
    end else begin
      hist.push_front(slow);
      void'(hist.pop_back());
      m_tick = tk;
      m_wrap = 1'b0;
      if (!m_run) begin
        m_leds = '0;
        if (en) begin
          m_run  = 1'b1;
          m_mode = mode;
          m_k    = 0;
          m_leds = pat(mode, 0);
        end
      end else if (!en) begin
        m_run  = 1'b0;
        m_leds = '0;
      end else if (tk) begin
        if (mode != m_mode) begin
          m_mode = mode;
          m_k    = 0;
          m_leds = pat(m_mode, 0);
        end else begin
          m_k    = (m_k + 1) % period(m_mode);
          m_leds = pat(m_mode, m_k);
          m_wrap = (m_k == 0);
        end
      end
    end
    #1;
    chk("leds", 32'(leds), 32'(m_leds));
    chk("tick", 32'(tick_o), 32'(m_tick));
    chk("wrap", 32'(wrap_o), 32'(m_wrap));
    if (wrap_o) wraps++;
  endtask

  task automatic pulse(input int hi, input int lo);
    slow = 1'b1;
    repeat (hi) cycle();
    slow = 1'b0;
    repeat (lo) cycle();
  endtask

  task automatic restart(input logic [1:0] m);
    en = 1'b0;
    cycle();
    mode = m;
    en = 1'b1;
    cycle();
    wraps = 0;
  endtask

  initial begin
    int r;
    hist  = '{1'b1, 1'b1, 1'b1};
    rst_n = 1'b0;
    slow  = 1'b1;
    en    = 1'b0;
    mode  = 2'd0;

    // reset settle with the slow clock held high
    repeat (4) cycle();
    rst_n = 1'b1;
    repeat (12) cycle();
    chk("settle_tick", 32'(tick_o), 32'd0);
    chk("settle_leds", 32'(leds), 32'd0);
    slow = 1'b0;
    repeat (3) cycle();

    // SHIFT full period
    restart(2'd0);
    chk("shift_init", 32'(leds), 32'h01);
    repeat (8) pulse(2, 2);
    chk("shift_end", 32'(leds), 32'h01);
    chk("shift_wraps", wraps, 1);

    // BOUNCE out and back plus one step
    restart(2'd1);
    repeat (15) pulse(2, 2);
    chk("bounce_end", 32'(leds), 32'h02);
    chk("bounce_wraps", wraps, 1);

    // FILL full period
    restart(2'd3);
    chk("fill_init", 32'(leds), 32'h00);
    repeat (9) pulse(2, 3);
    chk("fill_end", 32'(leds), 32'h00);
    chk("fill_wraps", wraps, 1);

    // BLINK full period
    restart(2'd2);
    chk("blink_init", 32'(leds), 32'hFF);
    repeat (2) pulse(3, 2);
    chk("blink_end", 32'(leds), 32'hFF);
    chk("blink_wraps", wraps, 1);

    // mode change waits for a tick, then loads FILL initial without wrap
    restart(2'd0);
    repeat (3) pulse(2, 2);
    chk("mc_before", 32'(leds), 32'h08);
    mode = 2'd3;
    repeat (4) cycle();
    chk("mc_hold", 32'(leds), 32'h08);
    wraps = 0;
    pulse(2, 2);
    chk("mc_load", 32'(leds), 32'h00);
    chk("mc_nowrap", wraps, 0);

    // disable on the tick edge: disable wins, tick still reported
    pulse(2, 2);
    chk("fill_step", 32'(leds), 32'h01);
    slow = 1'b1;
    repeat (2) cycle();
    en   = 1'b0;
    slow = 1'b0;
    cycle();
    chk("dis_leds", 32'(leds), 32'h00);
    chk("dis_wrap", 32'(wrap_o), 32'd0);
    chk("dis_tick", 32'(tick_o), 32'd1);
    cycle();
    mode = 2'd0;
    en   = 1'b1;
    cycle();
    chk("reen_leds", 32'(leds), 32'h01);

    // reset mid-BOUNCE on what would have been a tick edge
    restart(2'd1);
    repeat (5) pulse(2, 2);
    chk("bounce_mid", 32'(leds), 32'h20);
    slow = 1'b1;
    repeat (2) cycle();
    rst_n = 1'b0;
    cycle();
    chk("rst_leds", 32'(leds), 32'h00);
    chk("rst_tick", 32'(tick_o), 32'd0);
    chk("rst_wrap", 32'(wrap_o), 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("rst_release", 32'(leds), 32'h01);
    slow = 1'b0;
    repeat (3) cycle();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
      end else if (r < 3) begin
        en = ~en;
      end else if (r < 5) begin
        mode = 2'($urandom_range(0, 3));
      end
      if (r == 5) begin
        slow = 1'b1;
        repeat (2) cycle();
        en   = ~en;
        slow = 1'b0;
        repeat (2) cycle();
      end else begin
        pulse($urandom_range(2, 4), $urandom_range(2, 4));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
